// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: FSM state type, S-box size and default key length.
package arc4_pkg;

    localparam int S_SIZE         = 256;
    localparam int DEFAULT_KEYLEN = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_KSA  = 3'd2,
        ST_LEN  = 3'd3,
        ST_PRGA = 3'd4,
        ST_DONE = 3'd5
    } arc4_state_e;

endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// s_mem: 256x8 single-port S-box storage, synchronous read with 1-cycle latency.
// A read in the same cycle as a write to the same address returns the old data.
module s_mem
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr_i,
    input  logic [7:0] wrdata_i,
    input  logic       wren_i,
    output logic [7:0] rddata_o
);

    logic [7:0] mem_q [S_SIZE];

    // Write port plus registered read of the addressed entry.
    always_ff @(posedge clk) begin
        if (wren_i) begin
            mem_q[addr_i] <= wrdata_i;
        end
        rddata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryption of a length-prefixed message (pt[0] = L, payload pt[1..L]).
// Sequence IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE; KSA and PRGA walk internal phases
// (ph_q) because S is a single-port synchronous RAM.
// Optional build macro ARC4_CYCLE_COUNT_EN enables the saturating operation cycle counter.
//
// Handshake: en is a start request sampled only while rdy=1; the accepting clock edge
// latches key, rdy drops on the next cycle and en is ignored until rdy returns.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEYLEN = DEFAULT_KEYLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  rdy,
    input  logic [8*KEYLEN-1:0]   key,
    output logic [7:0]            pt_addr,
    input  logic [7:0]            pt_rddata,
    output logic [7:0]            ct_addr,
    output logic [7:0]            ct_wrdata,
    output logic                  ct_wren,
    output logic [15:0]           cycles,
    output arc4_state_e           dbg_state_o
);

    localparam int KW = 8 * KEYLEN;

    arc4_state_e state_q, state_d;
    logic [2:0]  ph_q, ph_d;
    logic [7:0]  i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [7:0]  k_q, k_d, len_q, len_d;
    logic [KW-1:0] key_q, key_d, key_rot;
    logic [7:0]  pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic        ct_wren_q, ct_wren_d;
    logic [7:0]  j_new;
    logic [7:0]  s_addr, s_wrdata, s_rddata;
    logic        s_wren;

    s_mem u_s_mem (
        .clk      (clk),
        .addr_i   (s_addr),
        .wrdata_i (s_wrdata),
        .wren_i   (s_wren),
        .rddata_o (s_rddata)
    );

    // Key bytes rotate left once per KSA step so the top byte is always key[i mod KEYLEN].
    assign key_rot = (key_q << 8) | (key_q >> (KW - 8));

    // New j: KSA adds the current key byte, PRGA does not.
    always_comb begin
        j_new = j_q + s_rddata;
        if (state_q == ST_KSA) begin
            j_new = j_new + key_q[KW-1 -: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_INIT;
            ST_INIT: if (i_q == 8'hFF) state_d = ST_KSA;
            ST_KSA:  if (ph_q == 3'd3 && i_q == 8'hFF) state_d = ST_LEN;
            ST_LEN:  if (ph_q == 3'd1) state_d = (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA;
            ST_PRGA: if (ph_q == 3'd5 && k_q == len_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready flag and S memory port control.
    always_comb begin
        rdy      = (state_q == ST_IDLE);
        s_addr   = i_q;
        s_wren   = 1'b0;
        s_wrdata = s_rddata;
        case (state_q)
            ST_INIT: begin
                s_wren   = 1'b1;
                s_wrdata = i_q;
            end
            ST_KSA, ST_PRGA: begin
                case (ph_q)
                    3'd0: s_addr = (state_q == ST_PRGA) ? i_q + 8'd1 : i_q;
                    3'd1: s_addr = j_new;
                    3'd2: s_wren = 1'b1;
                    3'd3: begin
                        s_addr   = j_q;
                        s_wren   = 1'b1;
                        s_wrdata = si_q;
                    end
                    default: s_addr = si_q + sj_q;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath next values: indices, swap temporaries, addresses and ct write.
    always_comb begin
        ph_d        = ph_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        k_d         = k_q;
        len_d       = len_q;
        key_d       = key_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    key_d = key;
                    i_d   = 8'd0;
                    j_d   = 8'd0;
                    ph_d  = 3'd0;
                end
            end
            ST_INIT: begin
                i_d  = i_q + 8'd1;
                ph_d = 3'd0;
            end
            ST_KSA: begin
                case (ph_q)
                    3'd0: ph_d = 3'd1;
                    3'd1: begin
                        si_d = s_rddata;
                        j_d  = j_new;
                        ph_d = 3'd2;
                    end
                    3'd2: ph_d = 3'd3;
                    default: begin
                        i_d   = i_q + 8'd1;
                        key_d = key_rot;
                        ph_d  = 3'd0;
                        if (i_q == 8'hFF) begin
                            j_d       = 8'd0;
                            pt_addr_d = 8'd0;
                        end
                    end
                endcase
            end
            ST_LEN: begin
                if (ph_q == 3'd0) begin
                    ph_d = 3'd1;
                end else begin
                    len_d       = pt_rddata;
                    k_d         = 8'd1;
                    ct_addr_d   = 8'd0;
                    ct_wrdata_d = pt_rddata;
                    ct_wren_d   = 1'b1;
                    ph_d        = 3'd0;
                end
            end
            ST_PRGA: begin
                case (ph_q)
                    3'd0: begin
                        i_d       = i_q + 8'd1;
                        pt_addr_d = k_q;
                        ph_d      = 3'd1;
                    end
                    3'd1: begin
                        si_d = s_rddata;
                        j_d  = j_new;
                        ph_d = 3'd2;
                    end
                    3'd2: begin
                        sj_d = s_rddata;
                        ph_d = 3'd3;
                    end
                    3'd3: ph_d = 3'd4;
                    3'd4: ph_d = 3'd5;
                    default: begin
                        ct_addr_d   = k_q;
                        ct_wrdata_d = pt_rddata ^ s_rddata;
                        ct_wren_d   = 1'b1;
                        k_d         = k_q + 8'd1;
                        ph_d        = 3'd0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q        <= 3'd0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            key_q       <= '0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            k_q         <= k_d;
            len_q       <= len_d;
            key_q       <= key_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
    end

    assign pt_addr     = pt_addr_q;
    assign ct_addr     = ct_addr_q;
    assign ct_wrdata   = ct_wrdata_q;
    assign ct_wren     = ct_wren_q;
    assign dbg_state_o = state_q;

`ifdef ARC4_CYCLE_COUNT_EN
    logic [15:0] cyc_q, cyc_d;

    // Count from the accept edge through DONE, saturating; hold until the next accept.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == ST_IDLE) begin
            if (en) cyc_d = 16'd1;
        end else if (cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycles = cyc_q;
`else
    assign cycles = 16'd0;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt with a high-level RC4 reference model.
module tb_arc4_encrypt;
  import arc4_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key = 24'd0;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic        ct_wren;
  logic [15:0] cycles;
  arc4_state_e dbg_state;

  always #5 clk = ~clk;

  arc4_encrypt #(.KEYLEN(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rdy         (rdy),
    .key         (key),
    .pt_addr     (pt_addr),
    .pt_rddata   (pt_rddata),
    .ct_addr     (ct_addr),
    .ct_wrdata   (ct_wrdata),
    .ct_wren     (ct_wren),
    .cycles      (cycles),
    .dbg_state_o (dbg_state)
  );

  // plaintext memory: synchronous read, 1-cycle latency
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  bit          ignore_wr = 1'b0;
  logic [15:0] exp_q[$];   // {addr, data} in required write order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rst_n && ct_wren) begin
      wr_cnt++;
      ct_mem[ct_addr] = ct_wrdata;
      if (!ignore_wr) begin
        if (exp_q.size() == 0) exp_w = 32'hFFFF_FFFF;
        else exp_w = {16'h0, exp_q.pop_front()};
        check("ct_write", {16'h0, ct_addr, ct_wrdata}, exp_w);
      end
    end
  end

  // RC4 reference: builds the full expected write stream from pt_mem and the key.
  task automatic model_push(input logic [23:0] k);
    int s [256];
    int kb [3];
    int i, j, t, len;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(pt_mem[0]);
    exp_q.push_back({8'd0, pt_mem[0]});
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_q.push_back({8'(n), pt_mem[n] ^ 8'(s[(s[i] + s[j]) % 256])});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_rdy(input string tag);
    for (int n = 0; n < 20000 && !rdy; n++) @(negedge clk);
    check({tag, "_rdy_timeout"}, {31'd0, rdy}, 32'd1);
  endtask

  task automatic run_op(input logic [23:0] k, input string tag);
    int len;
    len = int'(pt_mem[0]);
    for (int n = 0; n < 256; n++) ct_mem[n] = 8'h00;
    model_push(k);
    wr_cnt = 0;
    wait_rdy({tag, "_start"});
    key = k;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check({tag, "_rdy_drop"}, {31'd0, rdy}, 32'd0);
    wait_rdy({tag, "_end"});
    check({tag, "_writes"}, wr_cnt, len + 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_wren_idle"}, {31'd0, ct_wren}, 32'd0);
  endtask

  task automatic load_plaintext();
    string msg;
    msg = "Plaintext";
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n + 1] = msg[n];
  endtask

  task automatic check_golden(input string tag);
    logic [7:0] golden [10];
    golden = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < 10; n++) check($sformatf("%s_ct%0d", tag, n), {24'd0, ct_mem[n]}, {24'd0, golden[n]});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    check({tag, "_wren"}, {31'd0, ct_wren}, 32'd0);
    check({tag, "_pt_addr"}, {24'd0, pt_addr}, 32'd0);
    check({tag, "_ct_addr"}, {24'd0, ct_addr}, 32'd0);
    check({tag, "_ct_wrdata"}, {24'd0, ct_wrdata}, 32'd0);
    check({tag, "_cycles"}, {16'd0, cycles}, 32'd0);
  endtask

  // watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]  orig [256];
    logic [15:0] c1;
    logic [23:0] k1, k2;
    int          len;

    for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;

    // reset values while held
    #3 rst_n = 1'b0;
    #4;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // known-answer vector
    load_plaintext();
    run_op(24'h4B6579, "kat");
    check_golden("kat");
    check("kat_ct_addr_hold", {24'd0, ct_addr}, 32'd9);
    check("kat_pt_addr_hold", {24'd0, pt_addr}, 32'd9);
    c1 = cycles;
`ifdef ARC4_CYCLE_COUNT_EN
    n_tests++;
    assert (c1 != 16'd0) else begin
      n_fail++;
      $error("FAIL cycles_nonzero: observed %0h expected nonzero", c1);
    end
    run_op(24'h4B6579, "kat_rep");
    check_golden("kat_rep");
    check("cycles_repeat", {16'd0, cycles}, {16'd0, c1});
`else
    check("cycles_zero", {16'd0, c1}, 32'd0);
`endif

    // empty message
    pt_mem[0] = 8'd0;
    run_op(24'($urandom), "len0");
    check("len0_ct0", {24'd0, ct_mem[0]}, 32'd0);
    check("len0_rdy", {31'd0, rdy}, 32'd1);

    // random keys and lengths
    for (int r = 0; r < 3; r++) begin
      pt_mem[0] = 8'($urandom_range(1, 40));
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
      run_op(24'($urandom), $sformatf("rand%0d", r));
    end

    // maximum length round trip
    pt_mem[0] = 8'd255;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
    run_op(24'h000018, "max_enc");
    for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
    run_op(24'h000018, "max_dec");
    for (int n = 0; n < 256; n++) check($sformatf("max_roundtrip%0d", n), {24'd0, ct_mem[n]}, {24'd0, orig[n]});

    // reset during KSA
    load_plaintext();
    ignore_wr = 1'b1;
    wait_rdy("abort_ksa_start");
    key = 24'h4B6579;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (600) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("abort_ksa");
    @(negedge clk);
    rst_n = 1'b1;

    // reset during PRGA (after ct[0] and ct[1] are out)
    wr_cnt = 0;
    @(negedge clk);
    key = 24'h4B6579;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int n = 0; n < 5000 && wr_cnt < 2; n++) @(negedge clk);
    check("abort_prga_reached", {31'd0, (wr_cnt >= 2)}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("abort_prga");
    @(negedge clk);
    rst_n = 1'b1;
    ignore_wr = 1'b0;
    @(negedge clk);
    run_op(24'h4B6579, "after_abort");
    check_golden("after_abort");

    // en held high across two operations
    k1 = 24'($urandom);
    k2 = k1 ^ 24'h5A5A5A;
    pt_mem[0] = 8'd12;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    len = int'(pt_mem[0]);
    model_push(k1);
    model_push(k2);
    wr_cnt = 0;
    wait_rdy("b2b_start");
    key = k1;
    en = 1'b1;
    @(negedge clk);
    check("b2b_rdy_drop1", {31'd0, rdy}, 32'd0);
    key = k2;
    wait_rdy("b2b_mid");
    check("b2b_writes1", wr_cnt, len + 1);
    @(negedge clk);
    check("b2b_rdy_drop2", {31'd0, rdy}, 32'd0);
    en = 1'b0;
    wait_rdy("b2b_end");
    check("b2b_writes2", wr_cnt, 2 * (len + 1));
    check("b2b_q_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("b2b_no_third", {31'd0, rdy}, 32'd1);
    check("b2b_no_extra_writes", wr_cnt, 2 * (len + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
